// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
// FSM state encoding, pipeline NOP encoding and the per-stage enable/flush bundle.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] HZ_NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic pcWe;
      logic ifidWe;
      logic idexWe;
      logic exmemWe;
      logic memwbWe;
      logic ifidFlush;
      logic idexFlush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_NORMAL = '{pcWe: 1'b1, ifidWe: 1'b1, idexWe: 1'b1, exmemWe: 1'b1,
                                           memwbWe: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b0};
   localparam stage_ctrl_t CTRL_BUBBLE = '{pcWe: 1'b0, ifidWe: 1'b0, idexWe: 1'b1, exmemWe: 1'b1,
                                           memwbWe: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b1};
   localparam stage_ctrl_t CTRL_BRANCH = '{pcWe: 1'b1, ifidWe: 1'b1, idexWe: 1'b1, exmemWe: 1'b1,
                                           memwbWe: 1'b1, ifidFlush: 1'b1, idexFlush: 1'b1};
   localparam stage_ctrl_t CTRL_FREEZE = '{pcWe: 1'b0, ifidWe: 1'b0, idexWe: 1'b0, exmemWe: 1'b0,
                                           memwbWe: 1'b0, ifidFlush: 1'b0, idexFlush: 1'b0};
   localparam stage_ctrl_t CTRL_RESET  = '{pcWe: 1'b0, ifidWe: 1'b0, idexWe: 1'b0, exmemWe: 1'b0,
                                           memwbWe: 1'b0, ifidFlush: 1'b1, idexFlush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - hazard inputs and stage enable/flush outputs
// master: pipeline side driving hazard information; slave: the hazard controller.
interface pipeline_hazard_controller_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_branch_taken;
   logic                  mem_busy;
   logic                  pc_we;
   logic                  ifid_we;
   logic                  idex_we;
   logic                  exmem_we;
   logic                  memwb_we;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic [1:0]            state_o;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, state_o
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, state_o
   );

endinterface

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - wrapping cycle counters for stall, flush and memory-wait events
// Each counter advances by one on a cycle where its strobe is high.
module hazard_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stallInc,
   input  logic             flushInc,
   input  logic             memwaitInc,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt,
   output logic [CNT_W-1:0] memwaitCnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt   <= '0;
         flushCnt   <= '0;
         memwaitCnt <= '0;
      end else begin
         if (stallInc)   stallCnt   <= stallCnt + 1'b1;
         if (flushInc)   flushCnt   <= flushCnt + 1'b1;
         if (memwaitInc) memwaitCnt <= memwaitCnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, memory freeze and branch flush sequencer
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W     = 5,
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   pipeline_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]          perf_stall_cnt,
   output logic [CNT_W-1:0]          perf_flush_cnt,
   output logic [CNT_W-1:0]          perf_memwait_cnt
`endif
);

   localparam logic [2:0] StallLoad = 3'(LOAD_USE_STALL - 1);

   hz_state_t   state;
   hz_state_t   nextState;
   hz_state_t   evalState;
   logic [2:0]  scnt;
   logic [2:0]  nextScnt;
   logic        lu;
   logic        bubbleCyc;
   logic        flushCyc;
   stage_ctrl_t ctrl;

   assign lu = hz.ex_mem_read && (hz.ex_rd != '0) &&
               ((hz.id_uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         scnt  <= '0;
      end else begin
         state <= nextState;
         scnt  <= nextScnt;
      end
   end

   always_comb begin
      ctrl      = CTRL_NORMAL;
      nextState = RUN;
      nextScnt  = scnt;
      bubbleCyc = 1'b0;
      flushCyc  = 1'b0;

      // Leaving MEM_WAIT behaves exactly like the state that was frozen.
      evalState = state;
      if (state == MEM_WAIT) begin
         evalState = (scnt != '0) ? STALL : RUN;
      end

      case (evalState)
         RUN: begin
            nextScnt = '0;
            if (hz.ex_branch_taken) begin
               ctrl     = CTRL_BRANCH;
               flushCyc = 1'b1;
            end else if (lu) begin
               ctrl      = CTRL_BUBBLE;
               bubbleCyc = 1'b1;
               if (LOAD_USE_STALL > 1) begin
                  nextState = STALL;
                  nextScnt  = StallLoad;
               end
            end
         end
         STALL: begin
            if (hz.ex_branch_taken) begin
               ctrl      = CTRL_BRANCH;
               flushCyc  = 1'b1;
               nextScnt  = '0;
            end else begin
               ctrl      = CTRL_BUBBLE;
               bubbleCyc = 1'b1;
               if (scnt <= 3'd1) begin
                  nextScnt = '0;
               end else begin
                  nextScnt  = scnt - 3'd1;
                  nextState = STALL;
               end
            end
         end
         default: begin
            nextState = RUN;
            nextScnt  = '0;
         end
      endcase

      if (hz.mem_busy) begin
         ctrl      = CTRL_FREEZE;
         bubbleCyc = 1'b0;
         flushCyc  = 1'b0;
         nextState = MEM_WAIT;
         nextScnt  = scnt;
      end

      if (!(state inside {RUN, STALL, MEM_WAIT})) begin
         nextState = RUN;
         nextScnt  = '0;
      end

      if (reset) begin
         ctrl      = CTRL_RESET;
         bubbleCyc = 1'b0;
         flushCyc  = 1'b0;
      end
   end

   assign hz.pc_we      = ctrl.pcWe;
   assign hz.ifid_we    = ctrl.ifidWe;
   assign hz.idex_we    = ctrl.idexWe;
   assign hz.exmem_we   = ctrl.exmemWe;
   assign hz.memwb_we   = ctrl.memwbWe;
   assign hz.ifid_flush = ctrl.ifidFlush;
   assign hz.idex_flush = ctrl.idexFlush;
   assign hz.state_o    = state;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters #(
      .CNT_W (CNT_W)
   ) uPerf (
      .clk        (clk),
      .reset      (reset),
      .stallInc   (bubbleCyc),
      .flushInc   (flushCyc),
      .memwaitInc (hz.mem_busy && !reset),
      .stallCnt   (perf_stall_cnt),
      .flushCnt   (perf_flush_cnt),
      .memwaitCnt (perf_memwait_cnt)
   );
`else
   logic unusedStrobes;
   assign unusedStrobes = bubbleCyc ^ flushCyc;
`endif

endmodule
